// File: rtl/kb_pkg.sv
// Shared constants and types for the PS/2 key-event sequencer:
// prefix bytes, parser state encoding and the {ext, keyup, code} event record.
package kb_pkg;

  localparam logic [7:0] KB_PFX_EXT = 8'hE0;
  localparam logic [7:0] KB_PFX_BRK = 8'hF0;
  localparam int         KB_EVT_W   = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } kb_state_e;

  typedef struct packed {
    logic       ext;
    logic       keyup;
    logic [7:0] code;
  } kb_evt_t;

endpackage

// File: rtl/kb_event_sequencer_if.sv
// Byte-input / event-output bundle of the key-event sequencer.
// slave = sequencer side, master = decoder + consumer side.
interface kb_event_sequencer_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic             BYTE_VALID;
  logic [7:0]       BYTE_DATA;
  logic             FRAME_ERR;
  logic             EVT_VALID;
  logic             EVT_READY;
  logic [7:0]       EVT_CODE;
  logic             EVT_EXT;
  logic             EVT_KEYUP;
  logic             OVERFLOW;
  logic [LVL_W-1:0] FIFO_LEVEL;

  modport master (
    output BYTE_VALID, BYTE_DATA, FRAME_ERR, EVT_READY,
    input  EVT_VALID, EVT_CODE, EVT_EXT, EVT_KEYUP, OVERFLOW, FIFO_LEVEL
  );

  modport slave (
    input  BYTE_VALID, BYTE_DATA, FRAME_ERR, EVT_READY,
    output EVT_VALID, EVT_CODE, EVT_EXT, EVT_KEYUP, OVERFLOW, FIFO_LEVEL
  );

endinterface

// File: rtl/kb_event_fifo.sv
// Generic synchronous FIFO with a registered first-word-fall-through head.
// A push into an empty FIFO appears at the head after that edge; no same-cycle bypass.
module kb_event_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic             CLK,
  input  logic             SRST,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr_n;
  logic [LW-1:0]    level_n;
  logic             push_ok;
  logic             pop_ok;

  assign empty    = (level == '0);
  assign full     = (level == LW'(DEPTH));
  assign pop_ok   = pop & ~empty;
  assign push_ok  = push & (~full | pop_ok);
  assign rd_ptr_n = rd_ptr + AW'(pop_ok);
  assign level_n  = level + LW'(push_ok) - LW'(pop_ok);

  always_ff @(posedge CLK) begin
    if (push_ok && !SRST)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge CLK) begin
    if (SRST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      head   <= '0;
    end else begin
      rd_ptr <= rd_ptr_n;
      wr_ptr <= wr_ptr + AW'(push_ok);
      level  <= level_n;
      // Head comes from the incoming word only when nothing older survives this edge.
      if (level_n != '0)
        head <= (level == LW'(pop_ok)) ? din : mem[rd_ptr_n];
    end
  end

endmodule

// File: rtl/kb_event_sequencer.sv
// PS/2 scan-code byte stream -> {ext, keyup, code} key events, buffered in a small FIFO.
// Build option: KB_TIMEOUT_EN abandons a prefix sequence after TIMEOUT_CYC idle cycles.
module kb_event_sequencer
  import kb_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 2000
) (
  input  logic                 CLK,
  input  logic                 SRST,
  kb_event_sequencer_if.slave  bus
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("kb_event_sequencer: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYC >= 1");
  end

  kb_state_e        state;
  kb_evt_t          evt_in;
  kb_evt_t          evt_head;
  logic             push;
  logic             fifo_full;
  logic             fifo_empty;
  logic [LVL_W-1:0] fifo_level;
  logic             overflow_q;
  logic             is_e0;
  logic             is_f0;
  logic             byte_ok;

  assign is_e0   = (bus.BYTE_DATA == KB_PFX_EXT);
  assign is_f0   = (bus.BYTE_DATA == KB_PFX_BRK);
  assign byte_ok = bus.BYTE_VALID & ~bus.FRAME_ERR;

  // Emission is decoded from the current state so the event lands in the FIFO on the same edge.
  always_comb begin
    push   = 1'b0;
    evt_in = '0;
    if (byte_ok && !is_e0 && !is_f0) begin
      push         = 1'b1;
      evt_in.ext   = (state == EXT) || (state == EXT_BRK);
      evt_in.keyup = (state == BRK) || (state == EXT_BRK);
      evt_in.code  = bus.BYTE_DATA;
    end
  end

`ifdef KB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;

  assign tmo_hit = (state != IDLE) && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK) begin
    if (SRST || state == IDLE || bus.BYTE_VALID || bus.FRAME_ERR || tmo_hit)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + 1'b1;
  end
`endif

  always_ff @(posedge CLK) begin
    if (SRST)
      state <= IDLE;
    else if (bus.FRAME_ERR)
      state <= IDLE;
    else if (bus.BYTE_VALID) begin
      unique case (state)
        IDLE:    state <= is_e0 ? EXT : (is_f0 ? BRK : IDLE);
        EXT:     state <= is_f0 ? EXT_BRK : (is_e0 ? EXT : IDLE);
        BRK:     state <= is_e0 ? EXT_BRK : (is_f0 ? BRK : IDLE);
        EXT_BRK: state <= (is_e0 || is_f0) ? EXT_BRK : IDLE;
        default: state <= IDLE;
      endcase
    end
`ifdef KB_TIMEOUT_EN
    else if (tmo_hit)
      state <= IDLE;
`endif
  end

  always_ff @(posedge CLK) begin
    if (SRST)
      overflow_q <= 1'b0;
    else if (push && fifo_full && !(bus.EVT_READY && !fifo_empty))
      overflow_q <= 1'b1;
  end

  kb_event_fifo #(
    .WIDTH (KB_EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .SRST  (SRST),
    .push  (push),
    .din   (evt_in),
    .pop   (bus.EVT_READY),
    .head  (evt_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign bus.EVT_VALID  = ~fifo_empty;
  assign bus.EVT_CODE   = evt_head.code;
  assign bus.EVT_EXT    = evt_head.ext;
  assign bus.EVT_KEYUP  = evt_head.keyup;
  assign bus.OVERFLOW   = overflow_q;
  assign bus.FIFO_LEVEL = fifo_level;

endmodule

// File: tb/tb_kb_event_sequencer.sv
// Bench for kb_event_sequencer: directed scenarios plus random byte traffic,
// each cycle compared against a prefix-flag / event-queue reference model.
module tb_kb_event_sequencer;
  import kb_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 2000;

  logic CLK = 1'b0;
  logic SRST;
  always #5 CLK = ~CLK;

  kb_event_sequencer_if #(.FIFO_DEPTH(DEPTH)) bus ();

  kb_event_sequencer #(
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .CLK  (CLK),
    .SRST (SRST),
    .bus  (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: pending prefix flags and a queue of stored events.
  logic [9:0] mq[$];
  bit         m_ext, m_brk, m_ovf;
  int         m_idle;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 16'(bus.EVT_VALID), 16'(mq.size() != 0));
    chk({tag, ".level"}, 16'(bus.FIFO_LEVEL), 16'(mq.size()));
    chk({tag, ".ovf"}, 16'(bus.OVERFLOW), 16'(m_ovf));
    if (mq.size() != 0)
      chk({tag, ".head"}, 16'({bus.EVT_EXT, bus.EVT_KEYUP, bus.EVT_CODE}), 16'(mq[0]));
  endtask

  task automatic model_edge(input bit bv, input logic [7:0] d, input bit fe, input bit rdy);
    bit         pop;
    bit         emit;
    logic [9:0] ev;
    pop  = rdy && (mq.size() != 0);
    emit = 1'b0;
    ev   = '0;
    if (fe) begin
      m_ext = 0; m_brk = 0;
    end else if (bv) begin
      if (d == 8'hE0) m_ext = 1;
      else if (d == 8'hF0) m_brk = 1;
      else begin
        emit = 1'b1; ev = {m_ext, m_brk, d}; m_ext = 0; m_brk = 0;
      end
    end
`ifdef KB_TIMEOUT_EN
    if ((m_ext || m_brk) && !bv && !fe) begin
      m_idle++;
      if (m_idle == TMO) begin m_ext = 0; m_brk = 0; m_idle = 0; end
    end else m_idle = 0;
`endif
    if (pop) void'(mq.pop_front());
    if (emit) begin
      if (mq.size() == DEPTH) m_ovf = 1;
      else mq.push_back(ev);
    end
  endtask

  task automatic step(input string tag, input bit bv, input logic [7:0] d, input bit fe, input bit rdy);
    @(negedge CLK);
    SRST = 1'b0;
    bus.BYTE_VALID = bv; bus.BYTE_DATA = d; bus.FRAME_ERR = fe; bus.EVT_READY = rdy;
    @(posedge CLK);
    model_edge(bv, d, fe, rdy);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge CLK);
    SRST = 1'b1;
    // Active inputs during reset must be ignored.
    bus.BYTE_VALID = 1'b1; bus.BYTE_DATA = 8'h1C; bus.FRAME_ERR = 1'b0; bus.EVT_READY = 1'b1;
    @(posedge CLK);
    mq.delete(); m_ext = 0; m_brk = 0; m_ovf = 0; m_idle = 0;
    #1;
    chk({tag, ".rst_out"}, 16'({bus.EVT_VALID, bus.EVT_EXT, bus.EVT_KEYUP, bus.OVERFLOW}), 16'h0);
    chk({tag, ".rst_code"}, 16'(bus.EVT_CODE), 16'h0);
    chk({tag, ".rst_level"}, 16'(bus.FIFO_LEVEL), 16'h0);
  endtask

  logic [7:0] burst[5];
  logic [7:0] rb;
  int         r;

  initial begin
    SRST = 1'b1;
    bus.BYTE_VALID = 0; bus.BYTE_DATA = 0; bus.FRAME_ERR = 0; bus.EVT_READY = 0;
    burst = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};

    do_reset("reset0");

    step("make1c", 1, 8'h1C, 0, 0);
    chk("make1c.fields", 16'({bus.EVT_EXT, bus.EVT_KEYUP, bus.EVT_CODE}), 16'h01C);
    chk("make1c.level", 16'(bus.FIFO_LEVEL), 16'd1);
    step("make1c.pop", 0, 8'h00, 0, 1);
    chk("make1c.level0", 16'(bus.FIFO_LEVEL), 16'd0);

    step("brk.f0", 1, 8'hF0, 0, 0);
    chk("brk.no_evt", 16'(bus.EVT_VALID), 16'd0);
    step("brk.1c", 1, 8'h1C, 0, 0);
    chk("brk.fields", 16'({bus.EVT_EXT, bus.EVT_KEYUP, bus.EVT_CODE}), 16'h11C);
    step("brk.pop", 0, 8'h00, 0, 1);

    step("eb.e0", 1, 8'hE0, 0, 0);
    step("eb.f0", 1, 8'hF0, 0, 0);
    step("eb.74", 1, 8'h74, 0, 0);
    chk("eb.fields", 16'({bus.EVT_EXT, bus.EVT_KEYUP, bus.EVT_CODE}), 16'h374);
    step("eb.pop", 0, 8'h00, 0, 1);

    for (int i = 0; i < 5; i++) step("ovf.push", 1, burst[i], 0, 0);
    chk("ovf.level", 16'(bus.FIFO_LEVEL), 16'd4);
    chk("ovf.flag", 16'(bus.OVERFLOW), 16'd1);
    step("ovf.hold", 0, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("ovf.drain", 16'(bus.EVT_CODE), 16'(burst[i]));
      step("ovf.pop", 0, 8'h00, 0, 1);
    end
    chk("ovf.sticky", 16'(bus.OVERFLOW), 16'd1);
    do_reset("reset1");

    for (int i = 0; i < 4; i++) step("full.fill", 1, burst[i], 0, 0);
    step("full.pushpop", 1, 8'h2C, 0, 1);
    chk("full.level", 16'(bus.FIFO_LEVEL), 16'd4);
    chk("full.no_ovf", 16'(bus.OVERFLOW), 16'd0);
    for (int i = 0; i < 4; i++) step("full.drain", 0, 8'h00, 0, 1);

    step("empty.pushpop", 1, 8'h3A, 0, 1);
    chk("empty.level", 16'(bus.FIFO_LEVEL), 16'd1);
    step("empty.pop", 0, 8'h00, 0, 1);

    step("fe.f0", 1, 8'hF0, 0, 0);
    step("fe.err", 0, 8'h00, 1, 0);
    step("fe.1c", 1, 8'h1C, 0, 0);
    chk("fe.fields", 16'({bus.EVT_EXT, bus.EVT_KEYUP, bus.EVT_CODE}), 16'h01C);
    step("fe.pop", 0, 8'h00, 0, 1);

    step("fewin.f0", 1, 8'hF0, 0, 0);
    step("fewin.both", 1, 8'h1C, 1, 0);
    chk("fewin.dropped", 16'(bus.FIFO_LEVEL), 16'd0);
    step("fewin.1c", 1, 8'h1C, 0, 0);
    chk("fewin.fields", 16'({bus.EVT_EXT, bus.EVT_KEYUP, bus.EVT_CODE}), 16'h01C);
    step("fewin.pop", 0, 8'h00, 0, 1);

    step("srst.e0", 1, 8'hE0, 0, 0);
    do_reset("srst");
    step("srst.1c", 1, 8'h1C, 0, 0);
    chk("srst.fields", 16'({bus.EVT_EXT, bus.EVT_KEYUP, bus.EVT_CODE}), 16'h01C);
    step("srst.pop", 0, 8'h00, 0, 1);

    step("tmo.e0", 1, 8'hE0, 0, 0);
    for (int i = 0; i < TMO; i++) step("tmo.idle", 0, 8'h00, 0, 0);
    step("tmo.74", 1, 8'h74, 0, 0);
`ifdef KB_TIMEOUT_EN
    chk("tmo.fields", 16'({bus.EVT_EXT, bus.EVT_KEYUP, bus.EVT_CODE}), 16'h074);
`else
    chk("tmo.fields", 16'({bus.EVT_EXT, bus.EVT_KEYUP, bus.EVT_CODE}), 16'h274);
`endif
    step("tmo.pop", 0, 8'h00, 0, 1);

    do_reset("reset2");
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 3);
      rb = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom_range(0, 255));
      step("rand", $urandom_range(0, 9) < 6, rb, $urandom_range(0, 24) == 0,
           (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
